// File: rtl/ssd_driver.sv
// ssd_driver: drives a 4-digit multiplexed seven-segment display.
//
// The 13-bit binary input is converted to BCD by a sequential double-dabble
// engine. The engine needs 13 cycles per value. The finished BCD word is
// latched into the display register. A free-running refresh counter scans
// the four digits.
//
// Configuration macro:
//   SSD_BLANK_EN  - when defined, leading zeros are blanked. The units digit
//                   is always lit.
//
// Ports:
//   clk      in   single clock, all state on the rising edge
//   Reset    in   synchronous, active-high reset
//   num      in   [12:0] unsigned binary value to display (0..8191)
//   Anode    out  [3:0] digit enables, active-low (bit 3 = thousands)
//   LED_out  out  [6:0] segment cathodes {a,b,c,d,e,f,g}, active-low
//   busy     out  high while a conversion is in progress

// Per-digit double-dabble correction: a nibble of 5 or more gets +3 so
// that the following left shift carries correctly into the next decade.
module ssd_add3 (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);
  assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;
endmodule

module ssd_driver #(
  parameter int REFRESH_BITS = 20
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [12:0] num,
  output logic [3:0]  Anode,
  output logic [6:0]  LED_out,
  output logic        busy
);
  localparam int NUM_DIGITS = 4;
  localparam int DIG_W      = 4;
  localparam logic [3:0] LAST_STEP = 4'd12;

`ifdef SSD_BLANK_EN
  // After reset disp is 0, so the thousands digit is blank.
  localparam logic [6:0] LED_RST = 7'b1111111;
`else
  localparam logic [6:0] LED_RST = 7'b0000001;
`endif

  typedef enum logic {IDLE, CONVERT} state_e;

  state_e                   state_q, state_d;
  logic [12:0]              last_num_q, last_num_d;
  logic [12:0]              shift_q, shift_d;
  logic [15:0]              bcd_q, bcd_d;
  logic [15:0]              disp_q, disp_d;
  logic [3:0]               step_q, step_d;
  logic [REFRESH_BITS-1:0]  cnt_q, cnt_d;
  logic [3:0]               anode_q, anode_d;
  logic [6:0]               led_q, led_d;

  // Conversion datapath. Correct all four nibbles, then shift {bcd,shift}.
  logic [NUM_DIGITS-1:0][DIG_W-1:0] bcd_adj;
  logic [28:0]                      dd_shift;

  genvar g;
  for (g = 0; g < NUM_DIGITS; g++) begin : g_adj
    ssd_add3 u_add3 (
      .nib_i (bcd_q[g*DIG_W +: DIG_W]),
      .nib_o (bcd_adj[g])
    );
  end

  assign dd_shift = {bcd_adj, shift_q} << 1;

  // Display scan
  logic [1:0]                       sel;
  logic [1:0]                       dig_idx;
  logic [NUM_DIGITS-1:0][DIG_W-1:0] disp_dig;
  logic [3:0]                       cur_nib;
  logic                             blank;

  assign sel      = cnt_q[REFRESH_BITS-1 -: 2];
  assign dig_idx  = ~sel;            // sel 0 -> thousands (3), sel 3 -> units (0)
  assign disp_dig = disp_q;
  assign cur_nib  = disp_dig[dig_idx];

`ifdef SSD_BLANK_EN
  // lead_zero[i] is set when digit i and every more significant digit are
  // zero. The units digit never blanks, so a value of 0 still shows "0".
  logic [NUM_DIGITS-1:0] lead_zero;
  always_comb begin
    lead_zero    = '0;
    lead_zero[3] = (disp_dig[3] == 4'd0);
    lead_zero[2] = lead_zero[3] && (disp_dig[2] == 4'd0);
    lead_zero[1] = lead_zero[2] && (disp_dig[1] == 4'd0);
    lead_zero[0] = 1'b0;
  end
  assign blank = lead_zero[dig_idx];
`else
  assign blank = 1'b0;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Conversion FSM plus display registers
  always_comb begin
    state_d    = state_q;
    last_num_d = last_num_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    disp_d     = disp_q;
    step_d     = step_q;
    cnt_d      = cnt_q + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
    anode_d    = ~(4'b1000 >> sel);
    led_d      = blank ? 7'b1111111 : seg7(cur_nib);

    case (state_q)
      IDLE: begin
        // Changes that arrive during CONVERT are picked up here. last_num
        // still holds the value that was converted.
        if (num != last_num_q) begin
          last_num_d = num;
          shift_d    = num;
          bcd_d      = '0;
          step_d     = '0;
          state_d    = CONVERT;
        end
      end
      CONVERT: begin
        bcd_d   = dd_shift[28:13];
        shift_d = dd_shift[12:0];
        step_d  = step_q + 4'd1;
        if (step_q == LAST_STEP) begin
          // disp changes only here, so a partial result is never shown.
          disp_d  = dd_shift[28:13];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      last_num_q <= '0;
      shift_q    <= '0;
      bcd_q      <= '0;
      disp_q     <= '0;
      step_q     <= '0;
      cnt_q      <= '0;
      anode_q    <= 4'b0111;
      led_q      <= LED_RST;
    end else begin
      state_q    <= state_d;
      last_num_q <= last_num_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      disp_q     <= disp_d;
      step_q     <= step_d;
      cnt_q      <= cnt_d;
      anode_q    <= anode_d;
      led_q      <= led_d;
    end
  end

  assign busy    = (state_q == CONVERT);
  assign Anode   = anode_q;
  assign LED_out = led_q;

endmodule

// File: doc/ssd_driver.md
SSD_DRIVER -- requirements
Module: ssd_driver

Interface
REQ-001 SHALL have parameter REFRESH_BITS, default 20, width of the digit-refresh counter; top 2 bits select the digit.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port num  input  13  unsigned binary value from the datapath ssd output, 0..8191.
REQ-005 SHALL have port Anode  output  4  digit enables, active-low; bit 3 = thousands, bit 0 = units.
REQ-006 SHALL have port LED_out  output  7  segment cathodes {a,b,c,d,e,f,g}, active-low.
REQ-007 SHALL have port busy  output  1  high while a binary-to-BCD conversion is in progress.

Function
REQ-008 SHALL hold registers last_num[12:0], shift[12:0], bcd[15:0], disp[15:0] and a 4-bit step counter, plus a 2-state FSM: IDLE, CONVERT.
REQ-009 In IDLE, when num != last_num on a rising edge: last_num<=num, shift<=num, bcd<=0, step<=0, state<=CONVERT, busy=1 from the next cycle.
REQ-010 In IDLE, when num == last_num: no state change, busy=0.
REQ-011 In CONVERT, each cycle: add 3 to every BCD nibble >=5, then shift {bcd,shift} left by 1; step increments.
REQ-012 After the 13th shift (step==12): disp<=corrected/shifted bcd result, state<=IDLE, busy=0 the next cycle; total 13 cycles in CONVERT, display update visible 14 cycles after num change is sampled.
REQ-013 Changes of num while in CONVERT SHALL be ignored; on return to IDLE the comparison with last_num is re-evaluated, so the latest value is converted next.
REQ-014 Refresh counter SHALL increment every cycle and wrap from 2^REFRESH_BITS-1 to 0.
REQ-015 Digit select sel = counter[REFRESH_BITS-1:REFRESH_BITS-2]; sel 0..3 -> Anode 0111, 1011, 1101, 1110 showing disp[15:12], [11:8], [7:4], [3:0].
REQ-016 Anode and LED_out SHALL be registered (one cycle after sel/disp change).
REQ-017 Segment map 0..9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100; nibbles 10..15 (unreachable) -> 1111111.
REQ-018 disp SHALL only change at conversion end; displayed digits never show a partially converted value.

Reset
REQ-019 Reset SHALL force state=IDLE, last_num=0, disp=0, bcd=0, shift=0, step=0, counter=0, busy=0.
REQ-020 On the cycle after reset, Anode=0111 and LED_out=0000001 (1111111 if blanking enabled).
REQ-021 Reset asserted during CONVERT SHALL abort the conversion; disp returns to 0 and a non-zero num starts a new conversion the first cycle after Reset deasserts.

Configuration
REQ-022 Macro SSD_BLANK_EN SHALL enable leading-zero blanking; undefined -> all four digits always lit with their value.
REQ-023 With SSD_BLANK_EN: a digit SHALL drive LED_out=1111111 (Anode unchanged) when it and every more-significant digit are 0; units digit is never blanked (num=0 shows single "0").

Verification
REQ-024 Reset with num=0, REFRESH_BITS=4 -> busy stays 0; Anode cycles 0111,1011,1101,1110 every 4 cycles; all digits 0000001 (macro off).
REQ-025 num 0->1234 -> busy high 13 cycles, then disp=0x1234; segments 1001111, 0010010, 0000110, 1001100 on digits 3..0.
REQ-026 num=8191 -> disp=0x8191 after 14 cycles; no nibble >9.
REQ-027 num=1234, changed to 42 at conversion cycle 5 -> disp=0x1234 first, then busy reasserts and disp=0x0042 14 cycles later.
REQ-028 Reset pulsed at conversion cycle 7 of num=999 -> busy 0, disp=0 next cycle; conversion restarts, disp=0x0999 14 cycles after Reset low.
REQ-029 SSD_BLANK_EN defined, num=7 -> digits 3..1 LED_out=1111111, digit 0 =0001111; num=0 -> digit 0 =0000001.
